ex_mdu: RTL and testbench
=========================

# ex_mdu

Multiply/divide unit in the EX stage, started by the EX-stage `start` control bit. It performs MULT/MULTU in 2 cycles and DIV/DIVU as a 32-iteration restoring divide. It owns the HI/LO result registers and raises `busy` so hazard control can hold ID_EX and EX_MEM1 until `done`. HI/LO feed the EX-stage read mux whose output is latched into EX_MEM1 as RHLOut.

## Interface
Parameters:
- none (widths fixed at 32; iteration count is a package constant)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- flush  in  1  exception/eret cancel of the in-flight operation
- busy  out  1  operation in flight (states MUL, DIV, FIX)
- done  out  1  one-cycle pulse; HI/LO are valid and updated in this cycle
- hi  out  32  HI register (upper product / remainder)
- lo  out  32  LO register (lower product / quotient)

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start=1, flush=0:
  - Latch op and operands.
  - For DIV, latch |a|, |b| and the signs sa, sb.
  - Clear the counter and partial remainder.
  - MULT/MULTU go to MUL; DIV/DIVU go to DIV.
- MUL: compute the 64-bit product (signed for MULT, unsigned for MULTU), write {hi,lo}, go to DONE.
- DIV: one restoring step per cycle, MSB of the dividend first.
  - Remainder width is 33 bits.
  - Counter is 6 bits; go to FIX when the counter reaches 31 (32 steps).
- FIX:
  - Signed DIV: negate quotient if sa^sb; negate remainder if sa.
  - Write lo=quotient, hi=remainder, go to DONE.
- DONE: done=1 for one cycle, then IDLE. start is ignored in DONE.
- Divide by zero (b==0, signed or unsigned): hi=a, lo=32'hFFFF_FFFF, with full DIV latency.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0. This falls out naturally from the unsigned |a| path.
- start while busy or in DONE: ignored, no queuing.
- flush in any state: next state IDLE, no done, hi/lo keep their previous values.
  - flush together with start in IDLE: flush wins and the request is dropped.
- hi/lo change only in MUL or FIX. They hold between operations.

## Timing
- Reset (rst=0 at a clk edge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. An in-flight operation is abandoned.
- Start accepted at edge T:
  - MULT/MULTU: busy high in T+1, done and new hi/lo in T+2.
  - DIV/DIVU: busy high in T+1..T+33 (DIV T+1..T+32, FIX T+33), done in T+34.
- busy is a registered state decode with no combinational path from start. Hazard control must stall the same-cycle consumer using start itself.
- done is high exactly one cycle. hi/lo are already updated when done is high.
- Back-to-back: the earliest next accept is the cycle after DONE, i.e. at most one operation per (latency+1) cycles.

## Configuration
- MDU_EARLY_EXIT_EN
  - Defined: at accept, a DIV/DIVU with b!=0 and |b| > |a| (unsigned compare) goes directly to FIX with quotient=0, remainder=|a|. After sign fix this gives lo=0, hi=a, done at T+2.
  - Undefined: every divide takes the full 34-cycle latency.
  - Results are identical either way; only latency differs.

## Structure
- Shared package mdu_pkg:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU
  - state enum
  - MDU_DIV_ITER = 32
- One sub-module, mdu_div_step: combinational single restoring step.
  - Inputs: 33-bit remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.

## Test plan
- Reset mid-divide, then MULT a=32'hFFFF_FFFF, b=2 -> busy=0, hi=lo=0 after reset; the MULT gives done at T+2 with hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFE.
- MULTU a=32'hFFFF_FFFF, b=2 -> done at T+2, hi=1, lo=32'hFFFF_FFFE.
- DIV a=-7, b=2 -> done at T+34, lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- Boundary cases:
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
  - DIVU 5/0 -> lo=32'hFFFF_FFFF, hi=5 at T+34.
- Cancel and ignore:
  - Prior hi/lo=(2,14); start DIV, assert flush at T+10 -> busy=0 from T+11, no done pulse, hi=2, lo=14.
  - A second start asserted during busy is ignored.
- DIVU a=3, b=10 -> lo=0, hi=3. done at T+2 with MDU_EARLY_EXIT_EN defined, at T+34 without it.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Op encodings, FSM states and divide iteration count.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int MDU_DIV_ITER = 32;

  localparam logic [5:0] MDU_CNT_LAST =
    6'(MDU_DIV_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } mdu_state_e;

  function automatic logic [31:0] abs32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-divide step.
// Shifts in the next dividend bit and trial-subtracts the divisor.
module mdu_div_step (
  input  logic [32:0] rem,
  input  logic        dbit,
  input  logic [31:0] dvs,
  output logic [32:0] rem_nxt,
  output logic        qbit
);

  logic [33:0] shl;
  logic [32:0] diff;

  assign shl  = {rem, dbit};
  assign diff = shl[32:0] - {1'b0, dvs};
  assign qbit = (shl >= {2'b00, dvs});

  assign rem_nxt = qbit ? diff : shl[32:0];

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit owning HI/LO.
// Define MDU_EARLY_EXIT_EN to finish divides with |b|>|a| at once.
module ex_mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e state_q;
  mdu_state_e state_d;

  logic [1:0]  op_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [32:0] rem_q;
  logic [5:0]  cnt_q;
  logic        sa_q;
  logic        sb_q;
  logic        dz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        acc;
  logic        is_div;
  logic        sgn_in;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        early;

  assign acc    = (state_q == S_IDLE)
                & start & ~flush;
  assign is_div = op[1];
  assign sgn_in = ~op[0];
  assign abs_a  = abs32(a, is_div & sgn_in);
  assign abs_b  = abs32(b, is_div & sgn_in);

`ifdef MDU_EARLY_EXIT_EN
  assign early = is_div
               & (b != 32'd0)
               & (abs_b > abs_a);
`else
  assign early = 1'b0;
`endif

  logic [32:0] rem_nxt;
  logic        qbit;

  mdu_div_step u_step (
    .rem     (rem_q),
    .dbit    (x_q[31]),
    .dvs     (y_q),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  logic        msgn;
  logic [63:0] ext_x;
  logic [63:0] ext_y;
  logic [63:0] prod;

  assign msgn  = (op_q == MDU_MULT);
  assign ext_x = msgn ? {{32{x_q[31]}}, x_q}
                      : {32'd0, x_q};
  assign ext_y = msgn ? {{32{y_q[31]}}, y_q}
                      : {32'd0, y_q};
  assign prod  = ext_x * ext_y;

  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign q_fix = (sa_q ^ sb_q) ? (~x_q + 32'd1)
                               : x_q;
  assign r_fix = sa_q ? (~rem_q[31:0] + 32'd1)
                      : rem_q[31:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (!is_div)    state_d = S_MUL;
            else if (early) state_d = S_FIX;
            else            state_d = S_DIV;
          end
        end
        S_MUL:  state_d = S_DONE;
        S_DIV: begin
          if (cnt_q == MDU_CNT_LAST)
            state_d = S_FIX;
        end
        S_FIX:  state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == S_MUL),
      (state_q == S_DIV),
      (state_q == S_FIX):  busy = 1'b1;
      (state_q == S_DONE): done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q  <= MDU_MULT;
      x_q   <= '0;
      y_q   <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dz_q  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (acc) begin
        op_q  <= op;
        cnt_q <= '0;
        rem_q <= '0;
        dz_q  <= (b == 32'd0);
        sa_q  <= is_div & sgn_in & a[31];
        sb_q  <= is_div & sgn_in & b[31];
        if (is_div) begin
          y_q <= abs_b;
          if (early) begin
            x_q   <= '0;
            rem_q <= {1'b0, abs_a};
          end else begin
            x_q <= abs_a;
          end
        end else begin
          x_q <= a;
          y_q <= b;
        end
      end
      if (!flush) begin
        if (state_q == S_DIV) begin
          // quotient bits fill x_q as dividend bits leave
          x_q   <= {x_q[30:0], qbit};
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + 6'd1;
        end
        if (state_q == S_MUL) begin
          hi_q <= prod[63:32];
          lo_q <= prod[31:0];
        end
        if (state_q == S_FIX) begin
          hi_q <= r_fix;
          lo_q <= dz_q ? 32'hFFFF_FFFF : q_fix;
        end
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: vector table plus
// flush, ignored-start and reset corner sequences.
module tb_ex_mdu;
  import mdu_pkg::*;

`ifdef MDU_EARLY_EXIT_EN
  localparam int ELAT = 2;
`else
  localparam int ELAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  ex_mdu dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t v[13];

  int checks = 0;
  int passed = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  task automatic run_op(
    input  logic [1:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output int          lat,
    output logic [31:0] h,
    output logic [31:0] l,
    output logic        b1,
    output logic        dn_after
  );
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; h = '0; l = '0; b1 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) b1 = busy;
      if (done) begin
        lat = k; h = hi; l = lo;
        break;
      end
    end
    @(negedge clk);
    dn_after = done;
  endtask

  task automatic count_done(
    input  int n,
    output int dn,
    output int bz
  );
    dn = 0; bz = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bz++;
    end
  endtask

  int          lat;
  logic [31:0] h;
  logic [31:0] l;
  logic        b1;
  logic        dna;
  int          dn;
  int          bz;
  int          tl;

  initial begin
    v[0]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,
              32'd1, 32'hFFFF_FFFE, 2};
    v[1]  = '{MDU_MULT, 32'hFFFF_FFFF, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    v[2]  = '{MDU_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
              32'h3FFF_FFFF, 32'h0000_0001, 2};
    v[3]  = '{MDU_MULT, 32'hFFFF_FFFD, 32'd5,
              32'hFFFF_FFFF, 32'hFFFF_FFF1, 2};
    v[4]  = '{MDU_MULTU, 32'h1234_5678, 32'h10,
              32'd1, 32'h2345_6780, 2};
    v[5]  = '{MDU_DIV, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    v[6]  = '{MDU_DIVU, 32'd100, 32'd7,
              32'd2, 32'd14, 34};
    v[7]  = '{MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, 32'h8000_0000, 34};
    v[8]  = '{MDU_DIVU, 32'd5, 32'd0,
              32'd5, 32'hFFFF_FFFF, 34};
    v[9]  = '{MDU_DIV, 32'hFFFF_FFFB, 32'd0,
              32'hFFFF_FFFB, 32'hFFFF_FFFF, 34};
    v[10] = '{MDU_DIV, 32'd7, 32'hFFFF_FFFE,
              32'd1, 32'hFFFF_FFFD, 34};
    v[11] = '{MDU_DIVU, 32'd3, 32'd10,
              32'd3, 32'd0, ELAT};
    v[12] = '{MDU_DIV, 32'hFFFF_FFFD, 32'd10,
              32'hFFFF_FFFD, 32'd0, ELAT};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op(v[i].op, v[i].a, v[i].b,
             lat, h, l, b1, dna);
      chk($sformatf("v%0d lat", i),
          32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d hi", i), h, v[i].hi);
      chk($sformatf("v%0d lo", i), l, v[i].lo);
      chk($sformatf("v%0d busy1", i),
          {31'd0, b1}, 32'd1);
      chk($sformatf("v%0d pulse", i),
          {31'd0, dna}, 32'd0);
    end

    // flush mid-divide keeps HI/LO
    run_op(MDU_DIVU, 32'd100, 32'd7,
           lat, h, l, b1, dna);
    chk("pre hi", h, 32'd2);
    chk("pre lo", l, 32'd14);
    @(negedge clk);
    op = MDU_DIV; a = 32'hFFFF_FFF9;
    b = 32'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush busy", {31'd0, busy}, 32'd0);
    count_done(40, dn, bz);
    chk("flush done", 32'(dn), 32'd0);
    chk("flush hi", hi, 32'd2);
    chk("flush lo", lo, 32'd14);

    // flush wins over start in IDLE
    @(negedge clk);
    op = MDU_MULTU; a = 32'd9; b = 32'd9;
    start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    count_done(5, dn, bz);
    chk("fs busy", 32'(bz), 32'd0);
    chk("fs done", 32'(dn), 32'd0);
    chk("fs lo", lo, 32'd14);

    // second start while busy is dropped
    @(negedge clk);
    op = MDU_DIVU; a = 32'd200; b = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 op = MDU_MULTU; a = 32'd5; b = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    tl = -1;
    for (int k = 5; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        tl = k; h = hi; l = lo;
        break;
      end
    end
    chk("ign lat", 32'(tl), 32'd34);
    chk("ign hi", h, 32'd2);
    chk("ign lo", l, 32'd22);
    count_done(10, dn, bz);
    chk("ign busy", 32'(bz), 32'd0);
    chk("ign done", 32'(dn), 32'd0);
    chk("ign keep", lo, 32'd22);

    // reset during a divide
    @(negedge clk);
    op = MDU_DIVU; a = 32'd100; b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst busy", {31'd0, busy}, 32'd0);
    chk("mrst done", {31'd0, done}, 32'd0);
    chk("mrst hi", hi, 32'd0);
    chk("mrst lo", lo, 32'd0);
    run_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2,
           lat, h, l, b1, dna);
    chk("mrst lat", 32'(lat), 32'd2);
    chk("mrst mhi", h, 32'hFFFF_FFFF);
    chk("mrst mlo", l, 32'hFFFF_FFFE);
    count_done(40, dn, bz);
    chk("mrst stale", 32'(dn), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
